// File: rtl/window_gen_3x3_pkg.sv
// Shared constants and types for the 3x3 window generator: frame geometry,
// pixel width, centre-address width and window slot numbering.
package window_gen_3x3_pkg;

    localparam int IMG_W    = 640;
    localparam int IMG_H    = 480;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 19;
    localparam int WIN_TAPS = 9;
    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;

    localparam int SLOT_TOP_LEFT     = 0;
    localparam int SLOT_CENTRE       = 4;
    localparam int SLOT_BOTTOM_RIGHT = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // Slot k = 3*row + col; row 0 is the oldest line, col 0 the leftmost pixel.
    function automatic int win_slot(input int row, input int col);
        return row * WIN_COLS + col;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buf.sv
// One line of pixel storage: asynchronous read, write on the clock edge, so a
// read and write to the same column in one cycle returns the old contents.
module window_gen_3x3_line_buf
    import window_gen_3x3_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);

    pix_t mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator with exact row/column tracking.
// Optional WINGEN_SOF_RESYNC_EN: an accepted in_sof pixel restarts the frame count.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int FRAME_W = IMG_W,
    parameter int FRAME_H = IMG_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W-1:0]          in_data,
    input  logic                      in_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN_TAPS*PIX_W-1:0] out_win,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      frame_done
);

    localparam int COL_W = $clog2(FRAME_W);
    localparam int ROW_W = $clog2(FRAME_H);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(FRAME_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(FRAME_H - 1);
    localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(FRAME_W + 1);

    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [ADDR_W-1:0] idx_q, idx_d, cur_idx;

    logic [WIN_ROWS-1:0][1:0][PIX_W-1:0] sh_q, sh_d;
    logic [WIN_ROWS-1:0][PIX_W-1:0]      tap_new;
    pix_t b1_rdata, b2_rdata;

    logic                      out_valid_q, out_valid_d;
    logic [WIN_TAPS*PIX_W-1:0] out_win_q, out_win_d;
    logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
    logic                      frame_done_q, frame_done_d;

    logic accept, emit, last_pix;

`ifdef WINGEN_SOF_RESYNC_EN
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        cur_idx = idx_q;
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
            cur_idx = '0;
        end
    end
`else
    logic unused_sof;
    assign unused_sof = in_sof;

    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        cur_idx = idx_q;
    end
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign tap_new  = {in_data, b1_rdata, b2_rdata};
    assign emit     = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    // B1 holds line r-1 and B2 line r-2; B2 is refilled from B1's old value.
    window_gen_3x3_line_buf #(.DEPTH(FRAME_W)) u_line_buf_1 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (in_data),
        .rdata (b1_rdata)
    );

    window_gen_3x3_line_buf #(.DEPTH(FRAME_W)) u_line_buf_2 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (b1_rdata),
        .rdata (b2_rdata)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        idx_d = idx_q;
        sh_d  = sh_q;
        if (accept) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                sh_d[r] = {tap_new[r], sh_q[r][1]};
            end
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            idx_d = last_pix ? '0 : cur_idx + ADDR_W'(1);
        end
    end

    // The window is the two stored taps of each row plus the values arriving now.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_win_d    = out_win_q;
        out_addr_d   = out_addr_q;
        frame_done_d = frame_done_q;
        if (accept) begin
            out_valid_d  = emit;
            frame_done_d = emit && last_pix;
            if (emit) begin
                for (int r = 0; r < WIN_ROWS; r++) begin
                    out_win_d[win_slot(r, 0)*PIX_W +: PIX_W] = sh_q[r][0];
                    out_win_d[win_slot(r, 1)*PIX_W +: PIX_W] = sh_q[r][1];
                    out_win_d[win_slot(r, 2)*PIX_W +: PIX_W] = tap_new[r];
                end
                out_addr_d = cur_idx - CENTRE_OFS;
            end
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            idx_q        <= '0;
            sh_q         <= '0;
            out_valid_q  <= 1'b0;
            out_win_q    <= '0;
            out_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            out_valid_q  <= out_valid_d;
            out_win_q    <= out_win_d;
            out_addr_q   <= out_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_win    = out_win_q;
    assign out_addr   = out_addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a reduced 12x6 frame; expected windows
// come from a full-frame image copy kept by the bench.
module tb_window_gen_3x3;
    import window_gen_3x3_pkg::*;

    localparam int TB_W = 12;
    localparam int TB_H = 6;
    localparam int WINS = (TB_H - 2) * (TB_W - 2);

    typedef struct {
        logic [WIN_TAPS*PIX_W-1:0] win;
        logic [ADDR_W-1:0]         addr;
        logic                      done;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_sof = 1'b0;
    logic                      out_ready = 1'b0;
    logic [PIX_W-1:0]          in_data = '0;
    logic                      in_ready;
    logic                      out_valid;
    logic [WIN_TAPS*PIX_W-1:0] out_win;
    logic [ADDR_W-1:0]         out_addr;
    logic                      frame_done;

    exp_t sb[$];
    logic [PIX_W-1:0] img [TB_H][TB_W];
    int m_row = 0;
    int m_col = 0;
    int checks = 0;
    int fails = 0;
    int win_count = 0;
    int done_count = 0;
    int first_addr = -1;
    logic                      stall_prev = 1'b0;
    logic [WIN_TAPS*PIX_W-1:0] held_win;
    logic [ADDR_W-1:0]         held_addr;
    logic                      held_done;
    logic [WIN_TAPS*PIX_W-1:0] last_win;

    window_gen_3x3 #(.FRAME_W(TB_W), .FRAME_H(TB_H)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_win    (out_win),
        .out_addr   (out_addr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_accept();
        exp_t e;
`ifdef WINGEN_SOF_RESYNC_EN
        if (in_sof) begin
            m_row = 0;
            m_col = 0;
        end
`endif
        img[m_row][m_col] = in_data;
        if (m_row >= 2 && m_col >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(3*i+j)*PIX_W +: PIX_W] = img[m_row-2+i][m_col-2+j];
            e.addr = ADDR_W'((m_row - 1) * TB_W + (m_col - 1));
            e.done = (m_row == TB_H - 1) && (m_col == TB_W - 1);
            sb.push_back(e);
        end
        if (m_col == TB_W - 1) begin
            m_col = 0;
            m_row = (m_row == TB_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Monitor: handshake pops first, then newly accepted pixels feed the model.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                fails++;
                $display("[TB] FAIL in_ready: got %b required %b", in_ready, (!out_valid || out_ready));
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_win !== held_win || out_addr !== held_addr || frame_done !== held_done) begin
                    fails++;
                    $display("[TB] FAIL stall_hold: got v=%b win=%h addr=%0d done=%b required v=1 win=%h addr=%0d done=%b",
                             out_valid, out_win, out_addr, frame_done, held_win, held_addr, held_done);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL window: got unexpected addr=%0d required no window", out_addr);
                end else begin
                    e = sb.pop_front();
                    if (out_win !== e.win || out_addr !== e.addr || frame_done !== e.done) begin
                        fails++;
                        $display("[TB] FAIL window: got win=%h addr=%0d done=%b required win=%h addr=%0d done=%b",
                                 out_win, out_addr, frame_done, e.win, e.addr, e.done);
                    end
                end
                checks++;
                if ((int'(out_addr) % TB_W) == 0 || (int'(out_addr) % TB_W) == TB_W - 1) begin
                    fails++;
                    $display("[TB] FAIL border: got addr=%0d col=%0d required interior column", out_addr, int'(out_addr) % TB_W);
                end
                if (win_count == 0) first_addr = int'(out_addr);
                win_count++;
                if (frame_done) done_count++;
                last_win = out_win;
            end
            stall_prev = out_valid && !out_ready;
            held_win   = out_win;
            held_addr  = out_addr;
            held_done  = frame_done;
            if (in_valid && in_ready) model_accept();
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_row = 0;
        m_col = 0;
        win_count = 0;
        done_count = 0;
        first_addr = -1;
    endtask

    task automatic push_pixel(input logic [PIX_W-1:0] data, input logic sof, input int stall_pct);
        logic acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        in_data = data;
        in_sof = sof;
        while (!acc && tries < 200) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("[TB] FAIL push_pixel: accepted %b required 1 within %0d cycles", acc, tries);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        out_ready = 1'b0;
        @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done); end
        if (out_win !== '0) begin fails++; $display("[TB] FAIL reset_out_win: got %h required 0", out_win); end
        if (out_addr !== '0) begin fails++; $display("[TB] FAIL reset_out_addr: got %0d required 0", out_addr); end
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        logic [WIN_TAPS*PIX_W-1:0] exp_win;
        apply_reset();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp_win[(3*i+j)*PIX_W +: PIX_W] = PIX_W'((i * TB_W + j) % 256);
        for (int idx = 0; idx < TB_W * TB_H; idx++) begin
            push_pixel(PIX_W'(idx % 256), 1'b0, 0);
            if (idx == 2 * TB_W + 1) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL ramp_early: got out_valid=%b required 0", out_valid); end
                @(posedge clk);
                #1;
            end
            if (idx == 2 * TB_W + 2) begin
                @(negedge clk);
                checks += 2;
                if (out_valid !== 1'b1 || out_addr !== ADDR_W'(TB_W + 1)) begin
                    fails++;
                    $display("[TB] FAIL ramp_first: got v=%b addr=%0d required v=1 addr=%0d", out_valid, out_addr, TB_W + 1);
                end
                if (out_win !== exp_win) begin fails++; $display("[TB] FAIL ramp_first_win: got %h required %h", out_win, exp_win); end
                @(posedge clk);
                #1;
            end
        end
        drain();
        checks += 3;
        if (win_count != WINS) begin fails++; $display("[TB] FAIL ramp_count: got %0d required %0d", win_count, WINS); end
        if (done_count != 1) begin fails++; $display("[TB] FAIL ramp_done: got %0d required 1", done_count); end
        if (sb.size() != 0) begin fails++; $display("[TB] FAIL ramp_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int idx = 0; idx < 2 * TB_W * TB_H; idx++) push_pixel(PIX_W'($urandom), 1'b0, 30);
        drain();
        checks += 3;
        if (win_count != 2 * WINS) begin fails++; $display("[TB] FAIL stall_count: got %0d required %0d", win_count, 2 * WINS); end
        if (done_count != 2) begin fails++; $display("[TB] FAIL stall_done: got %0d required 2", done_count); end
        if (sb.size() != 0) begin fails++; $display("[TB] FAIL stall_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int idx = 0; idx < 40; idx++) push_pixel(PIX_W'($urandom), 1'b0, 30);
        apply_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid: got %b required 0", out_valid); end
        @(posedge clk);
        #1;
        for (int idx = 0; idx < TB_W * TB_H; idx++) push_pixel(PIX_W'(idx % 256), 1'b0, 0);
        drain();
        checks += 3;
        if (first_addr != TB_W + 1) begin fails++; $display("[TB] FAIL mid_reset_first: got %0d required %0d", first_addr, TB_W + 1); end
        if (win_count != WINS) begin fails++; $display("[TB] FAIL mid_reset_count: got %0d required %0d", win_count, WINS); end
        if (done_count != 1) begin fails++; $display("[TB] FAIL mid_reset_done: got %0d required 1", done_count); end
    endtask

    task automatic test_sof();
        apply_reset();
        for (int idx = 0; idx < 30; idx++) push_pixel(PIX_W'($urandom), 1'b0, 0);
        push_pixel(PIX_W'($urandom), 1'b1, 0);
        for (int idx = 1; idx < TB_W * TB_H; idx++) push_pixel(PIX_W'($urandom), 1'b0, 20);
        drain();
        checks += 3;
        if (win_count != WINS + 4) begin fails++; $display("[TB] FAIL sof_count: got %0d required %0d", win_count, WINS + 4); end
        if (done_count != 1) begin fails++; $display("[TB] FAIL sof_done: got %0d required 1", done_count); end
        if (sb.size() != 0) begin fails++; $display("[TB] FAIL sof_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [WIN_TAPS*PIX_W-1:0] all55;
        all55 = {WIN_TAPS{8'h55}};
        apply_reset();
        for (int idx = 0; idx < TB_W * TB_H; idx++) push_pixel(8'hAA, 1'b0, 0);
        for (int idx = 0; idx < TB_W * TB_H; idx++) push_pixel(8'h55, 1'b0, 0);
        drain();
        checks += 3;
        if (win_count != 2 * WINS) begin fails++; $display("[TB] FAIL b2b_count: got %0d required %0d", win_count, 2 * WINS); end
        if (done_count != 2) begin fails++; $display("[TB] FAIL b2b_done: got %0d required 2", done_count); end
        if (last_win !== all55) begin fails++; $display("[TB] FAIL b2b_last_win: got %h required %h", last_win, all55); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_mid_reset();
        test_sof();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator between the pixel receive path (MATLAB → FPGA, one 8-bit grey pixel per accepted beat, raster order) and the systolic window array. Two line buffers and three 3-tap shift rows present a complete 3x3 window plus the 19-bit frame address of its centre pixel. Only windows whose full neighbourhood lies inside the frame are emitted. This replaces address-range gating with exact row/column tracking.

## Interface
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- PIX_W, 8, bits per pixel
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input pixel present
- in_ready  out  1  block can accept pixel this cycle
- in_data  in  PIX_W  pixel value
- in_sof  in  1  marks first pixel of a frame (qualified by in_valid)
- out_valid  out  1  window present
- out_ready  in  1  consumer accepts window
- out_win  out  9*PIX_W  slot k = 3*row+col at [k*PIX_W +: PIX_W]; row 0 = oldest line, col 0 = leftmost; centre is k=4
- out_addr  out  19  centre address, (r-1)*IMG_W + (c-1)
- frame_done  out  1  one-cycle pulse with last window of frame

## Operation
- Input accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel; col wraps to 0 and row increments; after (IMG_H-1, IMG_W-1) both wrap to 0.
- Per accepted pixel at col c: line buffer B1[c] read (row r-1), B2[c] read (row r-2); B2[c] ← B1[c], B1[c] ← in_data; the three values shift into shift rows (bottom = in_data).
- Window emitted for the accepted pixel iff r ≥ 2 and c ≥ 2; centre is (r-1, c-1). Windows never span a line boundary.
- Emitted windows per frame: (IMG_H-2)*(IMG_W-2) = 304964; addresses run 641 … 306558, skipping border columns.
- frame_done asserted with the window for input (IMG_H-1, IMG_W-1), i.e. out_addr = 306558.
- Output register holds out_win/out_addr/frame_done stable while out_valid && !out_ready.
- Line buffer contents are not cleared by reset or frame start; stale data is never emitted because rows 0–1 of a new frame refill both buffers before any output.

## Timing
- Latency: window appears on out_valid the cycle after the completing pixel is accepted.
- Throughput: one window per cycle with out_ready held high.
- Line buffer read is same-cycle (distributed RAM) or pipelined with internal forwarding; either way the externally visible latency is 1 cycle.
- Reset values: out_valid 0, frame_done 0, out_win 0, out_addr 0, row/col 0, in_ready 1 the cycle after reset.
- Reset mid-frame: counters and output register cleared; the next accepted pixel is treated as (0,0).
- Simultaneous out handshake and new input: the register reloads in the same cycle with no bubble.

## Configuration
- WINGEN_SOF_RESYNC_EN defined: an accepted pixel with in_sof = 1 forces row = col = 0 for that pixel regardless of the current count. A partial preceding frame is abandoned with no frame_done.
- Undefined: in_sof is ignored; framing relies purely on the pixel count.

## Structure
- Shared package: IMG_W, IMG_H, PIX_W, ADDR_W = 19, WIN_TAPS = 9, and the window slot index constants (centre = 4).
- One sub-module, line_buf: single-port-read/write IMG_W x PIX_W RAM with read-before-write. It is instantiated twice.

## Test plan
- Ramp frame, pixel = (r*IMG_W + c) mod 256, out_ready = 1 → first window at out_addr 641 after input index 1282, with out_win = {0,1,2,128,129,130,0,1,2}; 304964 windows total; frame_done only at 306558.
- Random out_ready deasserts (30%) → no window lost or duplicated; out_win/out_addr stable while stalled; in_ready low exactly when stalled.
- Reset asserted at input index 100000 then a full frame → first window again at 641; no output from pre-reset data.
- With WINGEN_SOF_RESYNC_EN, in_sof at index 5000 of a frame → counters restart; next window at 641 after 1282 further pixels.
- Two back-to-back frames, constant pixel 0xAA then 0x55 → second frame windows all 0x55; exactly two frame_done pulses.
- Column border check → no window with out_addr mod 640 in {0, 639}.
